// File: rtl/decoder_3to8_pkg.sv
// decoder_3to8_pkg: widths, select type and output idle value for the
// registered 3-to-8 decoder. Polarity macro: DECODER_3TO8_ACTIVE_LOW_EN.
package decoder_3to8_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] out_t;

`ifdef DECODER_3TO8_ACTIVE_LOW_EN
    localparam out_t OUT_IDLE = 8'hFF;
`else
    localparam out_t OUT_IDLE = 8'h00;
`endif

    // Map an active-high word onto the configured output polarity.
    function automatic out_t apply_pol(input out_t hot);
`ifdef DECODER_3TO8_ACTIVE_LOW_EN
        return ~hot;
`else
        return hot;
`endif
    endfunction

endpackage

// File: rtl/decoder_3to8_if.sv
// decoder_3to8_if: select/enable inputs and decoded outputs.
// master drives en/A/B/C; slave (the decoder) drives out/out_vld.
interface decoder_3to8_if;
    import decoder_3to8_pkg::*;

    logic en;
    logic A;
    logic B;
    logic C;
    out_t out;
    logic out_vld;

    modport master (
        output en, A, B, C,
        input  out, out_vld
    );

    modport slave (
        input  en, A, B, C,
        output out, out_vld
    );

endinterface

// File: rtl/decoder_3to8_core.sv
// decoder_3to8_core: combinational select -> one-hot map with polarity.
// Ports: sel_i (3-bit select), dec_o (8-bit decoded word).
module decoder_3to8_core
    import decoder_3to8_pkg::*;
(
    input  sel_t sel_i,
    output out_t dec_o
);

    out_t hot;

    always_comb begin
        hot = '0;
        case (sel_i)
            3'd0: hot = 8'h01;
            3'd1: hot = 8'h02;
            3'd2: hot = 8'h04;
            3'd3: hot = 8'h08;
            3'd4: hot = 8'h10;
            3'd5: hot = 8'h20;
            3'd6: hot = 8'h40;
            3'd7: hot = 8'h80;
            // X/Z select in simulation: no line asserted.
            default: hot = '0;
        endcase
    end

    // Inversion of the all-zero guard yields OUT_IDLE in both builds.
    assign dec_o = apply_pol(hot);

endmodule

// File: rtl/decoder_3to8.sv
// decoder_3to8: registered 3-to-8 decoder, one cycle latency.
// Ports: sys_clk, sys_rst_n (sync, active-low), bus (slave modport:
// en, A, B, C in; out, out_vld out). Macro: DECODER_3TO8_ACTIVE_LOW_EN.
module decoder_3to8
    import decoder_3to8_pkg::*;
(
    input logic             sys_clk,
    input logic             sys_rst_n,
    decoder_3to8_if.slave   bus
);

    sel_t sel;
    out_t dec;
    out_t out_d;
    out_t out_q;
    logic vld_d;
    logic vld_q;

    assign sel = {bus.A, bus.B, bus.C};

    decoder_3to8_core u_core (
        .sel_i (sel),
        .dec_o (dec)
    );

    always_comb begin
        out_d = out_q;
        vld_d = vld_q;
        if (bus.en) begin
            out_d = dec;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            out_q <= OUT_IDLE;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.out_vld = vld_q;

    // Active-high view of the output, for the one-hot invariant.
    out_t hot_q;
    assign hot_q = apply_pol(out_q);

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n && vld_q)
            assert ($onehot(hot_q));
    end

endmodule

// File: tb/tb_decoder_3to8.sv
// tb_decoder_3to8: directed-vector bench for decoder_3to8.
// Honors DECODER_3TO8_ACTIVE_LOW_EN for expected values.
module tb_decoder_3to8;

    logic sys_clk;
    logic sys_rst_n;
    int   n_run;
    int   n_fail;

    decoder_3to8_if bus ();

    decoder_3to8 dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    logic [7:0] hot [8];
    initial begin
        hot[0] = 8'h01; hot[1] = 8'h02;
        hot[2] = 8'h04; hot[3] = 8'h08;
        hot[4] = 8'h10; hot[5] = 8'h20;
        hot[6] = 8'h40; hot[7] = 8'h80;
    end

`ifdef DECODER_3TO8_ACTIVE_LOW_EN
    localparam logic [7:0] IDLE = 8'hFF;
    function automatic logic [7:0] xp(input int n);
        return ~hot[n];
    endfunction
    function automatic logic [7:0] ah(input logic [7:0] v);
        return ~v;
    endfunction
`else
    localparam logic [7:0] IDLE = 8'h00;
    function automatic logic [7:0] xp(input int n);
        return hot[n];
    endfunction
    function automatic logic [7:0] ah(input logic [7:0] v);
        return v;
    endfunction
`endif

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input int n);
        logic [2:0] s;
        s = n[2:0];
        bus.A = s[2];
        bus.B = s[1];
        bus.C = s[0];
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_vld(input string tag, input logic exp);
        chk(tag, {7'd0, bus.out_vld}, {7'd0, exp});
    endtask

    initial begin
        int seq [4];
        n_run  = 0;
        n_fail = 0;
        sys_rst_n = 1'b0;
        bus.en = 1'b1;
        set_sel(5);

        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out", bus.out, IDLE);
            chk_vld("rst_vld", 1'b0);
        end

        sys_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_sel(i);
            #1;
            if (i > 0)
                chk("sweep_lag", bus.out, xp(i - 1));
            step();
            chk("sweep_out", bus.out, xp(i));
            chk_vld("sweep_vld", 1'b1);
            repeat (9) step();
            chk("sweep_hold", bus.out, xp(i));
        end

        set_sel(3);
        step();
        chk("hold_pre", bus.out, xp(3));
        bus.en = 1'b0;
        set_sel(6);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_out", bus.out, xp(3));
            chk_vld("hold_vld", 1'b1);
        end
        bus.en = 1'b1;
        step();
        chk("hold_rel", bus.out, xp(6));

        set_sel(7);
        step();
        chk("mrst_pre", bus.out, xp(7));
        sys_rst_n = 1'b0;
        step();
        chk("mrst_out", bus.out, IDLE);
        chk_vld("mrst_vld", 1'b0);
        sys_rst_n = 1'b1;
        set_sel(2);
        step();
        chk("mrst_rel", bus.out, xp(2));
        chk_vld("mrst_rvld", 1'b1);

        seq[0] = 0; seq[1] = 7; seq[2] = 1; seq[3] = 6;
        for (int i = 0; i < 4; i++) begin
            set_sel(seq[i]);
            step();
            chk("b2b_out", bus.out, xp(seq[i]));
            if (bus.out_vld)
                chk("b2b_onehot",
                    {7'd0, $onehot(ah(bus.out))}, 8'd1);
        end

`ifdef DECODER_3TO8_ACTIVE_LOW_EN
        set_sel(2);
        step();
        chk("pol_010", bus.out, 8'hFB);
        set_sel(7);
        step();
        chk("pol_111", bus.out, 8'h7F);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decoder_3to8.md
# decoder_3to8

Registered 3-to-8 one-hot decoder. It converts a 3-bit select formed from single-bit inputs A (MSB), B and C (LSB) into an 8-bit one-hot word. The output is latched on the system clock so downstream logic sees glitch-free select lines. It sits between control/select logic and the enable pins of eight downstream units (chip-selects, LED drivers, mux enables).

## Interface

- No parameters. Widths are fixed at 3 select bits and 8 outputs.
- Clocking: one clock; reset is synchronous and active-low.
- sys_clk  input  1  system clock; all state updates on its rising edge.
- sys_rst_n  input  1  synchronous active-low reset, sampled on the rising edge of sys_clk.
- en  input  1  decode enable; when 0, out holds its last value.
- A  input  1  select bit 2 (MSB).
- B  input  1  select bit 1.
- C  input  1  select bit 0 (LSB).
- out  output  8  one-hot decoded word. Bit n is asserted when {A,B,C} equals n.
- out_vld  output  1  high when out reflects a decode performed since reset.

## Operation

- Select index: sel = {A,B,C}, unsigned 0..7.
- Decode rule: out_next = 8'b1 << sel.
  - 000 gives 8'h01, 001 gives 8'h02, 010 gives 8'h04, 011 gives 8'h08.
  - 100 gives 8'h10, 101 gives 8'h20, 110 gives 8'h40, 111 gives 8'h80.
- Exactly one bit of out is asserted whenever out_vld is 1.
- When en is 0, out and out_vld hold their previous values and new select values are ignored.
- If any select bit is X or Z, out_next is 8'h00. This is a simulation-only guard, implemented with a default case branch.

## Timing

- Register update on each rising edge of sys_clk:
  - sys_rst_n is 0: out becomes the deasserted value (8'h00) and out_vld becomes 0.
  - sys_rst_n is 1 and en is 1: out becomes out_next and out_vld becomes 1.
  - sys_rst_n is 1 and en is 0: out and out_vld hold.
- Reset has priority over en. Reset asserted mid-operation clears both registers on the next rising edge, regardless of the select inputs.
- Latency is one cycle: select inputs sampled at rising edge k appear on out after edge k.
- No combinational path from the inputs to any output.
- Throughput: a new select can be decoded every cycle.
- A select change between clock edges is not visible until the next edge.

## Configuration

- Macro: DECODER_3TO8_ACTIVE_LOW_EN.
- Defined: out is active-low (~(8'b1 << sel)). Reset value is 8'hFF and the X/Z guard value is 8'hFF. out_vld is unaffected.
- Undefined (default): active-high one-hot as described above, reset value 8'h00.

## Structure

- Shared package decoder_3to8_pkg holds:
  - SEL_W = 3 and OUT_W = 8.
  - The out reset value, OUT_IDLE, selected by the macro.
  - The typedef sel_t, a 3-bit logic vector.
- One sub-module is natural: decoder_3to8_core.
  - It is the purely combinational sel to one-hot mapping, including the polarity handling.
  - The top module instantiates it and adds the output register stage with reset and enable.

## Test plan

- Reset: sys_rst_n=0 for 3 cycles with {A,B,C}=101 and en=1 → out=8'h00 and out_vld=0 throughout. Expect 8'hFF instead with DECODER_3TO8_ACTIVE_LOW_EN defined.
- Sweep: en=1, step {A,B,C} through 000 to 111, holding each value 200 ns → out is 01, 02, 04, 08, 10, 20, 40, 80, each one cycle after the change; out_vld=1.
- Hold: decode 011 (out=8'h08), then set en=0 and drive 110 for 5 cycles → out stays 8'h08. Raise en → out=8'h40 after one edge.
- Mid-operation reset: out=8'h80, pull sys_rst_n low for 1 cycle → out=8'h00 and out_vld=0 on that edge. On release with sel=010 and en=1 → out=8'h04 on the next edge.
- Back-to-back: change sel every cycle (000, 111, 001, 110) → out follows (01, 80, 02, 40) with exactly one cycle of lag. Check $onehot(out) on every cycle while out_vld=1.
- Polarity build: with DECODER_3TO8_ACTIVE_LOW_EN defined, sel=010 → out=8'hFB; sel=111 → out=8'h7F.
